// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost flags, sticky error flags, flush and selectable output timing.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit REG_OUT    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         clr_err,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] head;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Status flags decoded from the registered count, plus accept qualifiers.
  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == {CNT_W{1'b0}});
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
    head         = mem[rd_ptr];
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= {PTR_W{1'b0}};
      rd_ptr    <= {PTR_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= {PTR_W{1'b0}};
        rd_ptr <= {PTR_W{1'b0}};
        count  <= {CNT_W{1'b0}};
      end else begin
        if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
        if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      // A new error in the same cycle as clr_err wins.
      if (!flush && wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (!flush && rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  if (REG_OUT) begin : g_reg_out
    // Registered read port: data lands one edge after the accepted read.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= {DATA_WIDTH{1'b0}};
        rd_valid <= 1'b0;
      end else if (flush) begin
        rd_valid <= 1'b0;
      end else if (rd_acc) begin
        rd_data  <= head;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end else begin : g_show_ahead
    // Show-ahead read port: head word is visible whenever the FIFO holds data.
    always_comb begin
      rd_valid = rd_acc && !flush && !rst;
      if (empty) begin
        rd_data = {DATA_WIDTH{1'b0}};
      end else begin
        rd_data = head;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: show-ahead DEPTH=16, show-ahead
// DEPTH=12 (pointer wrap) and registered-output DEPTH=16 instances.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: DEPTH=16, show-ahead
  logic       a_flush, a_clr, a_we, a_re;
  logic [7:0] a_wd, a_rd_data;
  logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [4:0] a_count;
  // Instance B: DEPTH=12, show-ahead
  logic       b_flush, b_clr, b_we, b_re;
  logic [7:0] b_wd, b_rd_data;
  logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [3:0] b_count;
  // Instance C: DEPTH=16, registered output
  logic       c_rst, c_flush, c_clr, c_we, c_re;
  logic [7:0] c_wd, c_rd_data;
  logic       c_rd_valid, c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [4:0] c_count;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .REG_OUT(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .clr_err(a_clr), .wr_en(a_we), .wr_data(a_wd),
    .rd_en(a_re), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .overflow(a_ov), .underflow(a_un));

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(12), .AF_THRESH(10), .AE_THRESH(2), .REG_OUT(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .clr_err(b_clr), .wr_en(b_we), .wr_data(b_wd),
    .rd_en(b_re), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count), .overflow(b_ov), .underflow(b_un));

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .REG_OUT(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .flush(c_flush), .clr_err(c_clr), .wr_en(c_we), .wr_data(c_wd),
    .rd_en(c_re), .rd_data(c_rd_data), .rd_valid(c_rd_valid), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_count), .overflow(c_ov), .underflow(c_un));

  logic [7:0] aq[$];
  logic [7:0] bq[$];
  logic [7:0] cq[$];
  int   am = 0, bm = 0, cm = 0;
  logic aov = 1'b0, aun = 1'b0, cov = 1'b0, cun = 1'b0;
  logic [7:0] cdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cycle(input logic we, input logic [7:0] wd, input logic re,
                         input logic clr, input logic fl);
    logic w_ok, r_ok;
    logic [7:0] e;
    a_we = we; a_wd = wd; a_re = re; a_clr = clr; a_flush = fl;
    #1;
    r_ok = re && (am > 0) && !fl;
    w_ok = we && (am < 16) && !fl;
    if (re) begin
      check("a_rd_valid", 32'(a_rd_valid), 32'(r_ok));
      if (r_ok) begin
        e = aq.pop_front();
        check("a_rd_data", 32'(a_rd_data), 32'(e));
      end
    end
    if (!fl && we && am == 16) aov = 1'b1; else if (clr) aov = 1'b0;
    if (!fl && re && am == 0)  aun = 1'b1; else if (clr) aun = 1'b0;
    if (fl) begin
      am = 0;
      aq.delete();
    end else begin
      if (w_ok) begin aq.push_back(wd); am++; end
      if (r_ok) am--;
    end
    tick();
    check("a_count", 32'(a_count), 32'(am));
    check("a_full",  32'(a_full),  32'(am == 16));
    check("a_empty", 32'(a_empty), 32'(am == 0));
    check("a_af",    32'(a_af),    32'(am >= 14));
    check("a_ae",    32'(a_ae),    32'(am <= 2));
    check("a_ov",    32'(a_ov),    32'(aov));
    check("a_un",    32'(a_un),    32'(aun));
    a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0; a_flush = 1'b0;
  endtask

  task automatic b_cycle(input logic we, input logic [7:0] wd, input logic re);
    logic w_ok, r_ok;
    logic [7:0] e;
    b_we = we; b_wd = wd; b_re = re;
    #1;
    r_ok = re && (bm > 0);
    w_ok = we && (bm < 12);
    if (re) begin
      check("b_rd_valid", 32'(b_rd_valid), 32'(r_ok));
      if (r_ok) begin
        e = bq.pop_front();
        check("b_rd_data", 32'(b_rd_data), 32'(e));
      end
    end
    if (w_ok) begin bq.push_back(wd); bm++; end
    if (r_ok) bm--;
    tick();
    check("b_count", 32'(b_count), 32'(bm));
    check("b_full",  32'(b_full),  32'(bm == 12));
    check("b_empty", 32'(b_empty), 32'(bm == 0));
    check("b_af",    32'(b_af),    32'(bm >= 10));
    b_we = 1'b0; b_re = 1'b0;
  endtask

  task automatic c_cycle(input logic we, input logic [7:0] wd, input logic re,
                         input logic fl, input logic rs);
    logic w_ok, r_ok, ev;
    c_we = we; c_wd = wd; c_re = re; c_flush = fl; c_rst = rs;
    #1;
    ev = 1'b0;
    if (rs) begin
      cm = 0; cq.delete(); cov = 1'b0; cun = 1'b0; cdata = 8'h00;
    end else if (fl) begin
      cm = 0; cq.delete();
    end else begin
      r_ok = re && (cm > 0);
      w_ok = we && (cm < 16);
      if (we && cm == 16) cov = 1'b1;
      if (re && cm == 0)  cun = 1'b1;
      if (r_ok) begin cdata = cq.pop_front(); ev = 1'b1; cm--; end
      if (w_ok) begin cq.push_back(wd); cm++; end
    end
    tick();
    check("c_count",    32'(c_count),    32'(cm));
    check("c_empty",    32'(c_empty),    32'(cm == 0));
    check("c_full",     32'(c_full),     32'(cm == 16));
    check("c_ae",       32'(c_ae),       32'(cm <= 2));
    check("c_af",       32'(c_af),       32'(cm >= 14));
    check("c_rd_valid", 32'(c_rd_valid), 32'(ev));
    check("c_rd_data",  32'(c_rd_data),  32'(cdata));
    check("c_ov",       32'(c_ov),       32'(cov));
    check("c_un",       32'(c_un),       32'(cun));
    c_we = 1'b0; c_re = 1'b0; c_flush = 1'b0; c_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; c_rst = 1'b1;
    a_flush = 1'b0; a_clr = 1'b0; a_we = 1'b0; a_re = 1'b0; a_wd = 8'h00;
    b_flush = 1'b0; b_clr = 1'b0; b_we = 1'b0; b_re = 1'b0; b_wd = 8'h00;
    c_flush = 1'b0; c_clr = 1'b0; c_we = 1'b0; c_re = 1'b0; c_wd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; c_rst = 1'b0;

    check("rst_count",    32'(a_count),    32'd0);
    check("rst_empty",    32'(a_empty),    32'd1);
    check("rst_full",     32'(a_full),     32'd0);
    check("rst_ae",       32'(a_ae),       32'd1);
    check("rst_af",       32'(a_af),       32'd0);
    check("rst_ov",       32'(a_ov),       32'd0);
    check("rst_un",       32'(a_un),       32'd0);
    check("rst_rd_data",  32'(a_rd_data),  32'd0);
    check("rst_c_valid",  32'(c_rd_valid), 32'd0);
    check("rst_c_data",   32'(c_rd_data),  32'd0);

    // Fill, overflow attempt, clear error, drain
    for (int i = 0; i < 16; i++) a_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    a_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) a_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // Read+write while empty, then read back the written word
    a_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // Steady state at count 5
    for (int i = 0; i < 5; i++)  a_cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) a_cycle(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  a_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // Error set beats clear in the same cycle, then a plain clear
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // Flush with wr/rd requests pending
    for (int i = 0; i < 3; i++) a_cycle(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
    a_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    a_cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // DEPTH=12 wrap
    for (int i = 0; i < 10; i++) b_cycle(1'b1, 8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) b_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) b_cycle(1'b1, 8'h80 + 8'(i), 1'b0);
    b_cycle(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 12; i++) b_cycle(1'b0, 8'h00, 1'b1);

    // Registered output
    c_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    c_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    c_cycle(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
    c_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    c_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    c_cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) c_cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    c_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    c_cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    c_cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    c_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    c_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
